// File: rtl/shmcp_instr_sequencer.sv
// Instruction sequencer for the SHMCP 4-bit core.
// Buffers host instructions in a FIFO and issues them one at a time: a one-cycle load
// strobe followed by EXEC_CYCLES cycles of cpu_state high. HALT_OPC is consumed here and
// parks the sequencer until run is dropped.
module shmcp_instr_sequencer #(
    parameter int unsigned   DEPTH       = 8,
    parameter int unsigned   IW          = 8,
    parameter int unsigned   EXEC_CYCLES = 4,
    parameter logic [IW-1:0] HALT_OPC    = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   host_valid,
    input  logic [IW-1:0]          host_instr,
    output logic                   host_ready,
    output logic                   cpu_load,
    output logic [IW-1:0]          cpu_instr,
    output logic                   cpu_state,
    output logic                   busy,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [AW:0]   FullLevel = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ExecLast  = CW'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExec,
        StHalt
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            cpu_load_q;
    logic [IW-1:0]   cpu_instr_q;
    logic            cpu_state_q;
    logic            busy_q;
    logic            halted_q;

    logic [IW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;

    logic            push;
    logic            pop;
    logic [IW-1:0]   head;
    logic            head_is_halt;
    logic            can_start;

    // FIFO handshake and head decode
    always_comb begin
        host_ready   = (level_q != FullLevel);
        push         = host_valid && host_ready;
        pop          = (state_q == StLoad);
        head         = mem[rd_ptr_q];
        head_is_halt = (head == HALT_OPC);
        can_start    = run && (level_q != '0);
    end

    // Storage array; stale contents are harmless because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= host_instr;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Issue FSM with registered outputs; the head is stable from LOAD entry until its pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cpu_load_q  <= 1'b0;
            cpu_instr_q <= '0;
            cpu_state_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (can_start) begin
                        state_q    <= StLoad;
                        busy_q     <= 1'b1;
                        cpu_load_q <= !head_is_halt;
                        if (!head_is_halt) begin
                            cpu_instr_q <= head;
                        end
                    end
                end
                StLoad: begin
                    cpu_load_q <= 1'b0;
                    if (head_is_halt) begin
                        state_q  <= StHalt;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q     <= StExec;
                        cnt_q       <= ExecLast;
                        cpu_state_q <= 1'b1;
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        cpu_state_q <= 1'b0;
                        if (can_start) begin
                            // Back-to-back issue without an idle cycle
                            state_q    <= StLoad;
                            cpu_load_q <= !head_is_halt;
                            if (!head_is_halt) begin
                                cpu_instr_q <= head;
                            end
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHalt: begin
                    if (!run) begin
                        state_q  <= StIdle;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cpu_load  = cpu_load_q;
    assign cpu_instr = cpu_instr_q;
    assign cpu_state = cpu_state_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign level     = level_q;

endmodule

// File: tb/tb_shmcp_instr_sequencer.sv
// Self-checking bench for shmcp_instr_sequencer: randomized instruction payloads checked
// against a queue-based model of push order, issue timing and FIFO occupancy.
module tb_shmcp_instr_sequencer;

    localparam int DEPTH = 8;
    localparam int EXEC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_instr = 8'h00;
    logic       host_ready;
    logic       cpu_load;
    logic [7:0] cpu_instr;
    logic       cpu_state;
    logic       busy;
    logic       halted;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ff_seen = 0;

    // Model: every accepted word in push order, plus expected occupancy while nothing pops
    logic [7:0] mq[$];
    int         mlevel = 0;

    // Observed issue trace
    logic [7:0] issued[$];
    int         load_cyc[$];

    always #5 clk = ~clk;

    shmcp_instr_sequencer #(
        .DEPTH      (DEPTH),
        .IW         (8),
        .EXEC_CYCLES(EXEC),
        .HALT_OPC   (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .host_valid(host_valid),
        .host_instr(host_instr),
        .host_ready(host_ready),
        .cpu_load  (cpu_load),
        .cpu_instr (cpu_instr),
        .cpu_state (cpu_state),
        .busy      (busy),
        .halted    (halted),
        .level     (level)
    );

    // Record every load strobe mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (cpu_load === 1'b1) begin
            issued.push_back(cpu_instr);
            load_cyc.push_back(cyc);
            if (cpu_instr === 8'hFF) ff_seen++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_word();
        return 8'($urandom_range(254, 0));
    endfunction

    // One-cycle push; with chk set the expected host_ready comes from the model occupancy
    task automatic push(input logic [7:0] v, input bit chk);
        bit accept;
        host_valid = 1'b1;
        host_instr = v;
        accept = 1'b1;
        if (chk) begin
            accept = (mlevel < DEPTH);
            checks++;
            if (host_ready !== accept) begin
                errors++;
                $display("FAIL push_ready: host_ready=%0b expected %0b (model level %0d)",
                         host_ready, accept, mlevel);
            end
        end
        step();
        host_valid = 1'b0;
        if (accept) begin
            mq.push_back(v);
            if (chk) mlevel++;
        end
    endtask

    task automatic wait_loads(input int n, input int budget);
        int k = 0;
        while (issued.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (issued.size() < n) begin
            errors++;
            $display("FAIL wait_loads: saw %0d loads, expected %0d", issued.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", busy, budget);
        end
    endtask

    task automatic test_reset();
        run = 1'b0;
        mq.delete();
        mlevel = 0;
        checks++;
        if ({cpu_load, cpu_state, busy, halted, host_ready} !== 5'b00001 || cpu_instr !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial: load/state/busy/halted/ready=%b instr=%h expected 00001/00",
                     {cpu_load, cpu_state, busy, halted, host_ready}, cpu_instr);
        end
        for (int i = 0; i < 3; i++) push(rand_word(), 1'b1);
        checks++;
        if (level !== 4'(mlevel)) begin
            errors++;
            $display("FAIL reset_prefill_level: got %0d expected %0d", level, mlevel);
        end
        rst = 1'b0;
        step();
        step();
        checks++;
        if (level !== 4'd0 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: level=%0d ready=%0b expected 0/1", level, host_ready);
        end
        checks++;
        if ({cpu_load, cpu_state, busy, halted} !== 4'b0000 || cpu_instr !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: load/state/busy/halted=%b instr=%h expected 0000/00",
                     {cpu_load, cpu_state, busy, halted}, cpu_instr);
        end
        rst = 1'b1;
        mq.delete();
        mlevel = 0;
        run = 1'b1;
        step();
        step();
        run = 1'b0;
        checks++;
        if (busy !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL reset_empty_run: busy=%0b level=%0d expected 0/0", busy, level);
        end
    endtask

    task automatic test_single();
        logic [7:0] v;
        logic [9:0] hi;
        for (int k = 0; k < 3; k++) begin
            v = (k == 0) ? 8'h3A : rand_word();
            push(v, 1'b0);
            run = 1'b1;
            step();
            checks++;
            if ({cpu_load, cpu_state} !== 2'b10 || cpu_instr !== v) begin
                errors++;
                $display("FAIL single_load: load/state=%b instr=%h expected 10/%h",
                         {cpu_load, cpu_state}, cpu_instr, v);
            end
            hi = '0;
            for (int i = 0; i < 10; i++) begin
                step();
                hi[i] = cpu_state;
            end
            checks++;
            if (hi !== 10'((1 << EXEC) - 1)) begin
                errors++;
                $display("FAIL single_exec_window: cpu_state trace=%b expected %b",
                         hi, 10'((1 << EXEC) - 1));
            end
            checks++;
            if (busy !== 1'b0 || level !== 4'd0 || cpu_instr !== v) begin
                errors++;
                $display("FAIL single_after: busy=%0b level=%0d instr=%h expected 0/0/%h",
                         busy, level, cpu_instr, v);
            end
            run = 1'b0;
        end
    endtask

    task automatic test_full();
        int n;
        run = 1'b0;
        mq.delete();
        mlevel = 0;
        for (int i = 0; i < DEPTH; i++) push(rand_word(), 1'b1);
        checks++;
        if (host_ready !== 1'b0 || level !== 4'(DEPTH)) begin
            errors++;
            $display("FAIL full_state: ready=%0b level=%0d expected 0/%0d", host_ready, level, DEPTH);
        end
        push(rand_word(), 1'b1);
        checks++;
        if (level !== 4'(DEPTH)) begin
            errors++;
            $display("FAIL full_overflow: level=%0d expected %0d", level, DEPTH);
        end
        issued.delete();
        load_cyc.delete();
        run = 1'b1;
        wait_loads(3, 40);
        for (int i = 0; i < 3; i++) push(rand_word(), 1'b0);
        n = mq.size();
        wait_loads(n, 200);
        wait_idle(20);
        run = 1'b0;
        checks++;
        if (issued.size() !== n) begin
            errors++;
            $display("FAIL full_count: %0d loads expected %0d", issued.size(), n);
        end
        for (int i = 0; i < n && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== mq[i]) begin
                errors++;
                $display("FAIL full_order[%0d]: got %h expected %h", i, issued[i], mq[i]);
            end
        end
        for (int i = 1; i < load_cyc.size(); i++) begin
            checks++;
            if (load_cyc[i] - load_cyc[i-1] !== EXEC + 1) begin
                errors++;
                $display("FAIL full_period[%0d]: got %0d expected %0d",
                         i, load_cyc[i] - load_cyc[i-1], EXEC + 1);
            end
        end
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL full_drained: level=%0d expected 0", level);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(6, 2);
            run = 1'b0;
            mq.delete();
            mlevel = 0;
            for (int i = 0; i < n; i++) push(rand_word(), 1'b1);
            issued.delete();
            load_cyc.delete();
            run = 1'b1;
            wait_loads(n, 20 + n * 10);
            wait_idle(20);
            run = 1'b0;
            for (int i = 0; i < n && i < issued.size(); i++) begin
                checks++;
                if (issued[i] !== mq[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h expected %h", i, issued[i], mq[i]);
                end
            end
            for (int i = 1; i < load_cyc.size(); i++) begin
                checks++;
                if (load_cyc[i] - load_cyc[i-1] !== EXEC + 1) begin
                    errors++;
                    $display("FAIL b2b_period[%0d]: got %0d expected %0d",
                             i, load_cyc[i] - load_cyc[i-1], EXEC + 1);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] w;
        int k;
        issued.delete();
        ff_seen = 0;
        run = 1'b1;
        push(8'h11, 1'b0);
        push(8'hFF, 1'b0);
        push(8'h22, 1'b0);
        k = 0;
        while (halted !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        checks++;
        if (halted !== 1'b1 || level !== 4'd1) begin
            errors++;
            $display("FAIL halt_enter: halted=%0b level=%0d expected 1/1", halted, level);
        end
        checks++;
        if (issued.size() !== 1 || {cpu_state, busy, cpu_load} !== 3'b000) begin
            errors++;
            $display("FAIL halt_issue: loads=%0d state/busy/load=%b expected 1/000",
                     issued.size(), {cpu_state, busy, cpu_load});
        end
        for (int i = 0; i < 5; i++) step();
        w = rand_word();
        push(w, 1'b0);
        checks++;
        if (halted !== 1'b1 || level !== 4'd2 || issued.size() !== 1) begin
            errors++;
            $display("FAIL halt_hold: halted=%0b level=%0d loads=%0d expected 1/2/1",
                     halted, level, issued.size());
        end
        run = 1'b0;
        step();
        checks++;
        if (halted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_release: halted=%0b busy=%0b expected 0/0", halted, busy);
        end
        run = 1'b1;
        wait_loads(3, 40);
        wait_idle(20);
        run = 1'b0;
        checks++;
        if (issued.size() !== 3 || issued[0] !== 8'h11 || issued[1] !== 8'h22 || issued[2] !== w) begin
            errors++;
            $display("FAIL halt_order: %0d loads, got %h %h %h expected 11 22 %h",
                     issued.size(), issued[0], issued[1], issued[2], w);
        end
        checks++;
        if (ff_seen !== 0) begin
            errors++;
            $display("FAIL halt_forwarded: HALT opcode loaded %0d times, expected 0", ff_seen);
        end
    endtask

    task automatic test_run_drop();
        logic [7:0] a;
        int n;
        run = 1'b0;
        a = rand_word();
        push(a, 1'b0);
        push(rand_word(), 1'b0);
        push(rand_word(), 1'b0);
        issued.delete();
        run = 1'b1;
        step();
        checks++;
        if (cpu_load !== 1'b1 || cpu_instr !== a) begin
            errors++;
            $display("FAIL drop_load: load=%0b instr=%h expected 1/%h", cpu_load, cpu_instr, a);
        end
        n = 0;
        step();
        if (cpu_state === 1'b1) n++;
        step();
        if (cpu_state === 1'b1) n++;
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_state === 1'b1) n++;
        end
        checks++;
        if (n !== EXEC) begin
            errors++;
            $display("FAIL drop_exec_len: cpu_state high %0d cycles expected %0d", n, EXEC);
        end
        checks++;
        if (busy !== 1'b0 || level !== 4'd2 || issued.size() !== 1) begin
            errors++;
            $display("FAIL drop_idle: busy=%0b level=%0d loads=%0d expected 0/2/1",
                     busy, level, issued.size());
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        step();
        step();
        step();
        checks++;
        if (cpu_state !== 1'b1) begin
            errors++;
            $display("FAIL midrst_exec: cpu_state=%0b expected 1", cpu_state);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({cpu_state, cpu_load, busy} !== 3'b000 || level !== 4'd0 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_abort: state/load/busy=%b level=%0d ready=%0b expected 000/0/1",
                     {cpu_state, cpu_load, busy}, level, host_ready);
        end
        rst = 1'b1;
        issued.delete();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (issued.size() !== 0 || level !== 4'd0) begin
            errors++;
            $display("FAIL midrst_quiet: loads=%0d level=%0d expected 0/0", issued.size(), level);
        end
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_halt();
        test_run_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
